// File: rtl/pixel_window_steer.sv
// Two-word pixel buffer with an offset-selected NUM_OUT-lane output window.
// Build option EDGE_REPLICATE_EN: out-of-range lanes repeat the newest pixel.
module pixel_window_steer #(
  parameter int PIX_W        = 8,
  parameter int PIX_PER_WORD = 4,
  parameter int NUM_OUT      = 8,
  parameter int SEL_W        = $clog2(2 * PIX_PER_WORD)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PIX_W*PIX_PER_WORD-1:0] in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_sof,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PIX_W*NUM_OUT-1:0] out_data,
  output logic [1:0]               word_cnt
);

  localparam int PPW   = PIX_PER_WORD;
  localparam int NBUF  = 2 * PPW;
  localparam int IDX_W = SEL_W + $clog2(NUM_OUT) + 1;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [PIX_W*PPW-1:0]       r_word;
  logic                       r_valid;
  logic [PIX_W*NUM_OUT-1:0]   r_data;
  logic [PIX_W*NUM_OUT-1:0]   w_win;
  logic [PIX_W-1:0]           w_pix [NBUF];
  logic [PIX_W-1:0]           w_fill;
  logic                       w_ready;
  logic                       w_accept;
  logic                       w_load;

  assign w_ready   = en & (~r_valid | out_ready);
  assign w_accept  = in_valid & w_ready;
  assign in_ready  = w_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign word_cnt  = r_state;

`ifdef EDGE_REPLICATE_EN
  assign w_fill = in_data[(PPW-1)*PIX_W +: PIX_W];
`else
  assign w_fill = '0;
`endif

  // Next fill level; a window loads when a non-sof accept reaches FULL.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    if (w_accept) begin
      if (in_sof) begin
        w_state_nxt = S_ONE;
      end else begin
        unique case (r_state)
          S_EMPTY: w_state_nxt = S_ONE;
          S_ONE: begin
            w_state_nxt = S_FULL;
            w_load      = 1'b1;
          end
          S_FULL: begin
            w_state_nxt = S_FULL;
            w_load      = 1'b1;
          end
          default: w_state_nxt = S_EMPTY;
        endcase
      end
    end
  end

  // Window: low half is the held word, high half the incoming word.
  always_comb begin
    logic [IDX_W-1:0] v_idx;
    v_idx = '0;
    w_win = '0;
    for (int b = 0; b < NBUF; b++) begin
      if (b < PPW) begin
        w_pix[b] = r_word[b*PIX_W +: PIX_W];
      end else begin
        w_pix[b] = in_data[(b-PPW)*PIX_W +: PIX_W];
      end
    end
    for (int i = 0; i < NUM_OUT; i++) begin
      v_idx = IDX_W'(in_sel) + IDX_W'(i);
      if (v_idx < IDX_W'(NBUF)) begin
        w_win[i*PIX_W +: PIX_W] = w_pix[v_idx[SEL_W-1:0]];
      end else begin
        w_win[i*PIX_W +: PIX_W] = w_fill;
      end
    end
  end

  // Fill-level state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Newest accepted word; a sof word simply restarts the row here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word <= '0;
    end else if (w_accept) begin
      r_word <= in_data;
    end
  end

  // Output register: load beats drain so windows can stream back-to-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= w_win;
    end else if (en & out_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_window_steer.sv
// Directed bench for pixel_window_steer with hand-computed windows.
// Expected fill lanes follow EDGE_REPLICATE_EN when defined.
module tb_pixel_window_steer;

  logic        clk;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [2:0]  in_sel;
  logic        in_sof;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [1:0]  word_cnt;

  int n_chk;
  int n_err;

  pixel_window_steer dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d,
                       input logic [2:0] s, input logic f);
    in_valid = v;
    in_data  = d;
    in_sel   = s;
    in_sof   = f;
    #1;
  endtask

`ifdef EDGE_REPLICATE_EN
  localparam logic [63:0] EXP_SEL3  = 64'h8888888877665544;
  localparam logic [63:0] EXP_SEL3B = 64'h04040404030201CC;
  localparam logic [63:0] EXP_SEL7  = 64'hF4F4F4F4F4F4F4F4;
`else
  localparam logic [63:0] EXP_SEL3  = 64'h0000008877665544;
  localparam logic [63:0] EXP_SEL3B = 64'h00000004030201CC;
  localparam logic [63:0] EXP_SEL7  = 64'h00000000000000F4;
`endif

  initial begin
    n_chk     = 0;
    n_err     = 0;
    rst       = 1'b1;
    en        = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 1'b0);
    tick;
    tick;
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_cnt", 64'(word_cnt), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);

    // idle: no accept without in_valid
    tick;
    chk("idle_cnt", 64'(word_cnt), 64'd0);

    // first word of row
    drive(1'b1, 32'h44332211, 3'd0, 1'b1);
    tick;
    chk("sof_cnt", 64'(word_cnt), 64'd1);
    chk("sof_valid", 64'(out_valid), 64'd0);

    // second word completes window, sel=0
    drive(1'b1, 32'h88776655, 3'd0, 1'b0);
    tick;
    chk("w0_valid", 64'(out_valid), 64'd1);
    chk("w0_data", out_data, 64'h8877665544332211);
    chk("w0_cnt", 64'(word_cnt), 64'd2);

    // back-to-back in FULL
    out_ready = 1'b1;
    drive(1'b1, 32'hCCBBAA99, 3'd0, 1'b0);
    chk("b2b_ready", 64'(in_ready), 64'd1);
    tick;
    chk("b2b_valid", 64'(out_valid), 64'd1);
    chk("b2b_data", out_data, 64'hCCBBAA9988776655);
    chk("b2b_cnt", 64'(word_cnt), 64'd2);

    // stall: consumer not ready
    out_ready = 1'b0;
    drive(1'b1, 32'h11111111, 3'd0, 1'b0);
    chk("stall_ready", 64'(in_ready), 64'd0);
    tick;
    chk("stall_valid", 64'(out_valid), 64'd1);
    chk("stall_data", out_data, 64'hCCBBAA9988776655);

    // release: third word accepted same cycle, sel=3
    out_ready = 1'b1;
    drive(1'b1, 32'h04030201, 3'd3, 1'b0);
    chk("rel_ready", 64'(in_ready), 64'd1);
    tick;
    chk("rel_valid", 64'(out_valid), 64'd1);
    chk("rel_data", out_data, EXP_SEL3B);

    // new row, sel=3 window
    drive(1'b1, 32'h44332211, 3'd0, 1'b1);
    tick;
    chk("row2_valid", 64'(out_valid), 64'd0);
    chk("row2_cnt", 64'(word_cnt), 64'd1);
    drive(1'b1, 32'h88776655, 3'd3, 1'b0);
    tick;
    chk("sel3_data", out_data, EXP_SEL3);

    // sof while FULL restarts the row
    drive(1'b1, 32'h0D0C0B0A, 3'd0, 1'b1);
    tick;
    chk("sofull_valid", 64'(out_valid), 64'd0);
    chk("sofull_cnt", 64'(word_cnt), 64'd1);
    drive(1'b1, 32'h1D1C1B1A, 3'd0, 1'b0);
    tick;
    chk("sofull_data", out_data, 64'h1D1C1B1A0D0C0B0A);

    // en=0 freezes everything
    en = 1'b0;
    drive(1'b1, 32'hFFFFFFFF, 3'd1, 1'b0);
    chk("en0_ready", 64'(in_ready), 64'd0);
    tick;
    chk("en0_valid", 64'(out_valid), 64'd1);
    chk("en0_data", out_data, 64'h1D1C1B1A0D0C0B0A);
    chk("en0_cnt", 64'(word_cnt), 64'd2);

    // rst overrides en=0
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst2_valid", 64'(out_valid), 64'd0);
    chk("rst2_data", out_data, 64'd0);
    chk("rst2_cnt", 64'(word_cnt), 64'd0);

    // max offset: only last pixel in range
    en = 1'b1;
    drive(1'b1, 32'h00000000, 3'd0, 1'b1);
    tick;
    drive(1'b1, 32'hF4F3F2F1, 3'd7, 1'b0);
    tick;
    chk("sel7_data", out_data, EXP_SEL7);

    // EMPTY -> ONE without sof gives no window
    drive(1'b0, 32'h0, 3'd0, 1'b0);
    tick;
    chk("drain_valid", 64'(out_valid), 64'd0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    drive(1'b1, 32'h55555555, 3'd0, 1'b0);
    tick;
    chk("nosof_cnt", 64'(word_cnt), 64'd1);
    chk("nosof_valid", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
